// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolve controller: B-type funct3 codes,
// FSM state encoding and the sequential PC step.
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Cmp  = 2'd1,
    Resp = 2'd2
  } brState_e;

  // funct3 010/011 have no B-type meaning
  function automatic logic isIllegalF3(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_comparator.sv
// Branch comparator: equality and signed/unsigned less-than of two operands.
module branch_comparator #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] input1,
  input  logic [XLEN-1:0] input2,
  input  logic            BrUn,
  output logic            BrLt,
  output logic            BrEq
);

  assign BrEq = (input1 == input2);
  assign BrLt = BrUn ? (input1 < input2) : ($signed(input1) < $signed(input2));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves one conditional branch per handshake: compares the registered operands,
// computes the correct next PC and flags mispredicts for the fetch redirect.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_imm,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic             req_pred_taken,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [XLEN-1:0]  res_npc,
  output logic             res_redirect,
  output logic             res_illegal,
  output logic             res_misalign,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  brState_e        state;
  logic [2:0]      funct3Q;
  logic [XLEN-1:0] pcQ;
  logic [XLEN-1:0] immQ;
  logic [XLEN-1:0] rs1Q;
  logic [XLEN-1:0] rs2Q;
  logic            predQ;

  logic            brLt;
  logic            brEq;
  logic            condTaken;
  logic            illegal;
  logic            misalign;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallThrough;
  logic [XLEN-1:0] nextPc;
  logic            resHandshake;

  branch_comparator #(
    .XLEN(XLEN)
  ) uComparator (
    .input1(rs1Q),
    .input2(rs2Q),
    .BrUn  (funct3Q[1]),
    .BrLt  (brLt),
    .BrEq  (brEq)
  );

  always_comb begin
    condTaken = 1'b0;
    case (funct3Q)
      F3_BEQ:  condTaken = brEq;
      F3_BNE:  condTaken = ~brEq;
      F3_BLT:  condTaken = brLt;
      F3_BGE:  condTaken = ~brLt;
      F3_BLTU: condTaken = brLt;
      F3_BGEU: condTaken = ~brLt;
      default: condTaken = 1'b0;
    endcase
  end

  always_comb begin
    illegal     = isIllegalF3(funct3Q);
    target      = pcQ + immQ;
    fallThrough = pcQ + XLEN'(PC_STEP);
    misalign    = condTaken & (target[1:0] != 2'b00);
    // A misaligned target is reported instead of redirected; fetch keeps the fall-through
    nextPc      = (condTaken & ~misalign) ? target : fallThrough;
    redirect    = (condTaken != predQ) & ~misalign & ~illegal;
  end

  assign req_ready    = (state == Idle) & ~flush & ~rst;
  assign resHandshake = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= Idle;
      funct3Q       <= '0;
      pcQ           <= '0;
      immQ          <= '0;
      rs1Q          <= '0;
      rs2Q          <= '0;
      predQ         <= 1'b0;
      res_valid     <= 1'b0;
      res_taken     <= 1'b0;
      res_npc       <= '0;
      res_redirect  <= 1'b0;
      res_illegal   <= 1'b0;
      res_misalign  <= 1'b0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      // Handshake is counted even when a flush arrives in the same cycle
      if (resHandshake) begin
        if (stat_branches != '1) begin
          stat_branches <= stat_branches + CNT_W'(1);
        end
        if (res_redirect && (stat_mispred != '1)) begin
          stat_mispred <= stat_mispred + CNT_W'(1);
        end
      end

      case (state)
        Idle: begin
          if (req_valid && req_ready) begin
            funct3Q <= req_funct3;
            pcQ     <= req_pc;
            immQ    <= req_imm;
            rs1Q    <= req_rs1;
            rs2Q    <= req_rs2;
            predQ   <= req_pred_taken;
            state   <= Cmp;
          end
        end
        Cmp: begin
          if (flush) begin
            state <= Idle;
          end else begin
            res_valid    <= 1'b1;
            res_taken    <= condTaken;
            res_npc      <= nextPc;
            res_redirect <= redirect;
            res_illegal  <= illegal;
            res_misalign <= misalign;
            state        <= Resp;
          end
        end
        Resp: begin
          if (res_ready || flush) begin
            res_valid <= 1'b0;
            state     <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table, multi-cycle corner
// sequences and randomized branches against a behavioural model.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc;
  logic [31:0] req_imm;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        req_pred_taken;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [31:0] res_npc;
  logic        res_redirect;
  logic        res_illegal;
  logic        res_misalign;
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;

  // Narrow-counter copy on the same stimulus, so saturation is reachable quickly
  logic        sReqReady;
  logic        sResValid;
  logic        sResTaken;
  logic [31:0] sResNpc;
  logic        sResRedirect;
  logic        sResIllegal;
  logic        sResMisalign;
  logic [2:0]  sStatBranches;
  logic [2:0]  sStatMispred;

  int nChecks = 0;
  int nFail   = 0;
  int mBr     = 0;
  int mMis    = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .XLEN (32),
    .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_pc        (req_pc),
    .req_imm       (req_imm),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_pred_taken(req_pred_taken),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_taken     (res_taken),
    .res_npc       (res_npc),
    .res_redirect  (res_redirect),
    .res_illegal   (res_illegal),
    .res_misalign  (res_misalign),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  branch_resolve_ctrl #(
    .XLEN (32),
    .CNT_W(3)
  ) dutSmall (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (sReqReady),
    .req_funct3    (req_funct3),
    .req_pc        (req_pc),
    .req_imm       (req_imm),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_pred_taken(req_pred_taken),
    .res_valid     (sResValid),
    .res_ready     (res_ready),
    .res_taken     (sResTaken),
    .res_npc       (sResNpc),
    .res_redirect  (sResRedirect),
    .res_illegal   (sResIllegal),
    .res_misalign  (sResMisalign),
    .stat_branches (sStatBranches),
    .stat_mispred  (sStatMispred)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        expT;
    logic [31:0] expNpc;
    logic        expR;
    logic        expI;
    logic        expM;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkStats(input string name);
    chk({name, " stat_branches"}, 32'(stat_branches), 32'((mBr > 65535) ? 65535 : mBr));
    chk({name, " stat_mispred"}, 32'(stat_mispred), 32'((mMis > 65535) ? 65535 : mMis));
    chk({name, " small stat_branches"}, 32'(sStatBranches), 32'((mBr > 7) ? 7 : mBr));
    chk({name, " small stat_mispred"}, 32'(sStatMispred), 32'((mMis > 7) ? 7 : mMis));
  endtask

  // Behavioural reference: RISC-V branch semantics computed directly
  task automatic refModel(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] a, input logic [31:0] b, input logic pred,
                          output logic t, output logic [31:0] npc, output logic r,
                          output logic ill, output logic mis);
    logic [31:0] tgt;
    int signed sa;
    int signed sb;
    sa  = a;
    sb  = b;
    ill = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = (sa < sb);
      3'd5:    t = (sa >= sb);
      3'd6:    t = (a < b);
      3'd7:    t = (a >= b);
      default: t = 1'b0;
    endcase
    tgt = pc + imm;
    mis = t && (tgt % 4 != 0);
    npc = (t && !mis) ? tgt : pc + 32'd4;
    r   = (t != pred) && !mis && !ill;
  endtask

  task automatic chkFields(input string name, input logic t, input logic [31:0] npc,
                           input logic r, input logic ill, input logic mis);
    chk({name, " taken"}, 32'(res_taken), 32'(t));
    chk({name, " npc"}, res_npc, npc);
    chk({name, " redirect"}, 32'(res_redirect), 32'(r));
    chk({name, " illegal"}, 32'(res_illegal), 32'(ill));
    chk({name, " misalign"}, 32'(res_misalign), 32'(mis));
  endtask

  task automatic runBranch(input string name, input logic [2:0] f3, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                           input logic pred, input logic expT, input logic [31:0] expNpc,
                           input logic expR, input logic expI, input logic expM,
                           input int hold, input logic flushAtResp);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    req_funct3     = f3;
    req_pc         = pc;
    req_imm        = imm;
    req_rs1        = a;
    req_rs2        = b;
    req_pred_taken = pred;
    req_valid      = 1'b1;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      chk({name, " accept timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, " valid at +1"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    chk({name, " valid at +2"}, 32'(res_valid), 32'd1);
    chkFields(name, expT, expNpc, expR, expI, expM);
    if (hold > 0) begin
      res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({name, " hold valid"}, 32'(res_valid), 32'd1);
        chk({name, " hold req_ready"}, 32'(req_ready), 32'd0);
        chk({name, " hold npc"}, res_npc, expNpc);
        chk({name, " hold redirect"}, 32'(res_redirect), 32'(expR));
      end
      res_ready = 1'b1;
    end
    flush = flushAtResp;
    @(negedge clk);
    flush = 1'b0;
    mBr++;
    if (expR) mMis++;
    chk({name, " valid after handshake"}, 32'(res_valid), 32'd0);
    chkStats(name);
  endtask

  initial begin
    logic        t;
    logic        r;
    logic        ill;
    logic        mis;
    logic [31:0] npc;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    int          hold;

    vecs[0] = '{name:"blt", f3:3'b100, pc:32'h100, imm:32'h20, a:32'hFFFFFFFF, b:32'h1,
                pred:1'b0, expT:1'b1, expNpc:32'h120, expR:1'b1, expI:1'b0, expM:1'b0};
    vecs[1] = '{name:"bltu", f3:3'b110, pc:32'h100, imm:32'h20, a:32'hFFFFFFFF, b:32'h1,
                pred:1'b0, expT:1'b0, expNpc:32'h104, expR:1'b0, expI:1'b0, expM:1'b0};
    vecs[2] = '{name:"beq wrap", f3:3'b000, pc:32'hFFFFFFF0, imm:32'h20, a:32'h5, b:32'h5,
                pred:1'b1, expT:1'b1, expNpc:32'h10, expR:1'b0, expI:1'b0, expM:1'b0};
    vecs[3] = '{name:"f3 010", f3:3'b010, pc:32'h200, imm:32'h40, a:32'h7, b:32'h7,
                pred:1'b1, expT:1'b0, expNpc:32'h204, expR:1'b0, expI:1'b1, expM:1'b0};
    vecs[4] = '{name:"bne misalign", f3:3'b001, pc:32'h300, imm:32'h6, a:32'h1, b:32'h2,
                pred:1'b0, expT:1'b1, expNpc:32'h304, expR:1'b0, expI:1'b0, expM:1'b1};
    vecs[5] = '{name:"bge back", f3:3'b101, pc:32'h400, imm:32'hFFFFFFF0, a:32'h3,
                b:32'hFFFFFFFF, pred:1'b0, expT:1'b1, expNpc:32'h3F0, expR:1'b1, expI:1'b0,
                expM:1'b0};
    vecs[6] = '{name:"bgeu", f3:3'b111, pc:32'h400, imm:32'hFFFFFFF0, a:32'h3,
                b:32'hFFFFFFFF, pred:1'b1, expT:1'b0, expNpc:32'h404, expR:1'b1, expI:1'b0,
                expM:1'b0};
    vecs[7] = '{name:"f3 011", f3:3'b011, pc:32'h500, imm:32'h8, a:32'h0, b:32'h0,
                pred:1'b0, expT:1'b0, expNpc:32'h504, expR:1'b0, expI:1'b1, expM:1'b0};

    rst = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    req_funct3 = '0;
    req_pc = '0;
    req_imm = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_pred_taken = 1'b0;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chkFields("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkStats("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      runBranch(vecs[i].name, vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].a, vecs[i].b,
                vecs[i].pred, vecs[i].expT, vecs[i].expNpc, vecs[i].expR, vecs[i].expI,
                vecs[i].expM, 0, 1'b0);
    end

    // Backpressure: result held for 5 cycles, counted once on release
    runBranch("stall", 3'b100, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1, 1'b0,
              1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 5, 1'b0);

    // Flush while comparing: branch vanishes, nothing counted
    @(negedge clk);
    req_funct3 = 3'b100; req_pc = 32'h100; req_imm = 32'h20;
    req_rs1 = 32'hFFFFFFFF; req_rs2 = 32'h1; req_pred_taken = 1'b0;
    req_valid = 1'b1;
    chk("flush cmp req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush cmp res_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    chk("flush cmp back idle", 32'(req_ready), 32'd1);
    chkStats("flush cmp");

    // Flush with a request: not accepted
    req_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush req req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush req res_valid", 32'(res_valid), 32'd0);
    end

    // Flush with a result handshake: still counted
    runBranch("flush hs", 3'b001, 32'h600, 32'h10, 32'h1, 32'h2, 1'b0,
              1'b1, 32'h610, 1'b1, 1'b0, 1'b0, 0, 1'b1);

    // Flush in RESP without handshake: dropped, not counted
    @(negedge clk);
    req_funct3 = 3'b000; req_pc = 32'h700; req_imm = 32'h8;
    req_rs1 = 32'h9; req_rs2 = 32'h9; req_pred_taken = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush resp valid", 32'(res_valid), 32'd1);
    res_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    res_ready = 1'b1;
    chk("flush resp dropped", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("flush resp still idle", 32'(res_valid), 32'd0);
    chkStats("flush resp");

    // Reset asserted mid-RESP clears everything at once
    req_funct3 = 3'b100; req_pc = 32'h100; req_imm = 32'h20;
    req_rs1 = 32'hFFFFFFFF; req_rs2 = 32'h1; req_pred_taken = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    chk("pre-reset valid", 32'(res_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    mBr = 0;
    mMis = 0;
    chk("mid reset res_valid", 32'(res_valid), 32'd0);
    chk("mid reset req_ready", 32'(req_ready), 32'd0);
    chkFields("mid reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkStats("mid reset");
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;

    for (int n = 0; n < 150; n++) begin
      f3   = 3'($urandom_range(7));
      a    = $urandom;
      b    = ($urandom_range(3) == 0) ? a : $urandom;
      pc   = $urandom & 32'hFFFFFFFC;
      imm  = ($urandom_range(1) == 1) ? (($urandom & 32'h1FFE) - 32'h1000) : $urandom;
      pred = 1'($urandom_range(1));
      hold = ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0;
      refModel(f3, pc, imm, a, b, pred, t, npc, r, ill, mis);
      runBranch("random", f3, pc, imm, a, b, pred, t, npc, r, ill, mis, hold, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
